// File: rtl/regfile_pkg.sv
// Shared register-file constants and the flat register-array type used by
// both the write bank and the external read muxes.
package regfile_pkg;

    localparam int unsigned DATA_W   = 64;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef logic [NUM_REGS-1:0][DATA_W-1:0] reg_array_t;

endpackage

// File: rtl/regfile_write_bank_if.sv
// Write port, register contents and write-back echo between the pipeline
// (master) and the register write bank (slave).
interface regfile_write_bank_if;
    import regfile_pkg::*;

    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_data;
    reg_array_t           regs_out;
    logic                 last_wr_valid;
    logic [ADDR_W-1:0]    last_wr_addr;
    logic [DATA_W-1:0]    last_wr_data;

    modport master (
        output wr_en, wr_addr, wr_data,
        input  regs_out, last_wr_valid, last_wr_addr, last_wr_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        output regs_out, last_wr_valid, last_wr_addr, last_wr_data
    );

endinterface

// File: rtl/regfile_write_bank_decoder5_32.sv
// 5:32 one-hot write-enable decoder, all outputs low when en is low.
module decoder5_32
    import regfile_pkg::*;
(
    input  logic                en,
    input  logic [ADDR_W-1:0]   addr,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_bank.sv
// Architectural register write bank: 31 enabled registers plus a hardwired
// zero register, with a one-cycle write-back echo for hazard detection.
module regfile_write_bank #(
    parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
    parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_write_bank_if.slave  bus
);
    import regfile_pkg::*;

    logic [NUM_REGS-1:0] wen;
    logic                unused_xzr_wen;

    decoder5_32 u_dec (
        .en     (bus.wr_en),
        .addr   (bus.wr_addr),
        .onehot (wen)
    );

    // The zero register has no storage, so its decoded enable goes nowhere.
    assign unused_xzr_wen = wen[ZERO_REG];

    for (genvar i = 0; i < int'(NUM_REGS) - 1; i++) begin : g_reg
        logic [DATA_W-1:0] q;

        always_ff @(posedge clk) begin
            if (reset) begin
                q <= '0;
            end else if (wen[i]) begin
                q <= bus.wr_data;
            end
        end

        assign bus.regs_out[i] = q;
    end

    assign bus.regs_out[ZERO_REG] = '0;

    // Echo of the write just retired; valid only when storage actually changed.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.last_wr_valid <= 1'b0;
            bus.last_wr_addr  <= '0;
            bus.last_wr_data  <= '0;
        end else begin
            bus.last_wr_valid <= bus.wr_en && (bus.wr_addr != ZERO_REG);
            bus.last_wr_addr  <= bus.wr_addr;
            bus.last_wr_data  <= bus.wr_data;
        end
    end

endmodule

// File: tb/tb_regfile_write_bank.sv
// Scoreboard bench for regfile_write_bank: directed cases followed by a
// random write stream, checked against an array-based register model.
module tb_regfile_write_bank;
    import regfile_pkg::*;

    typedef struct {
        reg_array_t        regs;
        bit                valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk;
    logic reset;
    regfile_write_bank_if bus ();

    regfile_write_bank dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] model [NUM_REGS];
    exp_t              expq [$];
    int                n_checks = 0;
    int                n_fail   = 0;

    // Reference: reset clears everything, otherwise a write to any index but
    // the zero register replaces that entry; the echo reflects the inputs.
    task automatic model_edge(input bit r, input bit e, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d);
        exp_t x;
        if (r) begin
            for (int i = 0; i < int'(NUM_REGS); i++) model[i] = '0;
        end else if (e && a != 5'd31) begin
            model[a] = d;
        end
        for (int i = 0; i < int'(NUM_REGS); i++) x.regs[i] = model[i];
        x.valid = !r && e && (a != 5'd31);
        x.addr  = r ? 5'd0 : a;
        x.data  = r ? 64'd0 : d;
        expq.push_back(x);
    endtask

    task automatic step(input bit r, input bit e, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
        reset       = r;
        bus.wr_en   = e;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(posedge clk);
        model_edge(r, e, a, d);
        #1;
    endtask

    // Monitor: every edge produces a new register state; compare it mid-cycle.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                x = expq.pop_front();
                n_checks++;
                if (bus.regs_out !== x.regs) begin
                    n_fail++;
                    for (int i = 0; i < int'(NUM_REGS); i++) begin
                        if (bus.regs_out[i] !== x.regs[i]) begin
                            $display("FAIL regs_out[%0d] at %0t: got %h expected %h",
                                     i, $time, bus.regs_out[i], x.regs[i]);
                            break;
                        end
                    end
                end
                n_checks++;
                if (bus.last_wr_valid !== x.valid) begin
                    n_fail++;
                    $display("FAIL last_wr_valid at %0t: got %b expected %b",
                             $time, bus.last_wr_valid, x.valid);
                end
                n_checks++;
                if (bus.last_wr_addr !== x.addr) begin
                    n_fail++;
                    $display("FAIL last_wr_addr at %0t: got %0d expected %0d",
                             $time, bus.last_wr_addr, x.addr);
                end
                n_checks++;
                if (bus.last_wr_data !== x.data) begin
                    n_fail++;
                    $display("FAIL last_wr_data at %0t: got %h expected %h",
                             $time, bus.last_wr_data, x.data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit                e;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        bit                r;

        for (int i = 0; i < int'(NUM_REGS); i++) model[i] = '0;
        reset = 1'b1; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        #1;

        step(1'b1, 1'b0, 5'd0, 64'd0);
        step(1'b1, 1'b0, 5'd0, 64'd0);
        step(1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF_0000_0005);
        step(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b0, 1'b0, 5'd7, 64'h1234);
        step(1'b0, 1'b1, 5'd3, 64'd1);
        step(1'b0, 1'b1, 5'd3, 64'd2);
        for (int i = 0; i < 31; i++) begin
            step(1'b0, 1'b1, 5'(i), 64'(i + 100));
        end
        step(1'b1, 1'b1, 5'd0, 64'd9);
        step(1'b0, 1'b1, 5'd0, 64'd9);
        step(1'b0, 1'b1, 5'd31, 64'd77);
        step(1'b0, 1'b1, 5'd30, 64'hA5A5_A5A5_5A5A_5A5A);

        for (int n = 0; n < 1000; n++) begin
            r = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            d = {$urandom, $urandom};
            step(r, e, a, d);
        end
        step(1'b0, 1'b0, 5'd0, 64'd0);

        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_bank.md
REGFILE_WRITE_BANK -- requirements
Module: regfile_write_bank

Interface
REQ-001 Parameter DATA_W, default 64: width of each architectural register.
REQ-002 Parameter NUM_REGS, default 32: number of architectural registers; fixed to 32 by the 5-bit address.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  write request for the current cycle.
REQ-006 wr_addr  input  5  destination register index.
REQ-007 wr_data  input  64  value to store.
REQ-008 regs_out  output  [31:0][63:0]  current contents of all 32 registers; feeds the 64-bit 32:1 read muxes directly.
REQ-009 last_wr_valid  output  1  a register was actually written on the previous edge.
REQ-010 last_wr_addr  output  5  index written on the previous edge; meaningful only when last_wr_valid=1.
REQ-011 last_wr_data  output  64  value written on the previous edge; meaningful only when last_wr_valid=1.

Function
REQ-012 Decode wr_addr one-hot through a 5:32 decoder gated by wr_en; at most one register enable is active per cycle.
REQ-013 On a rising edge with wr_en=1 and wr_addr!=31, registers[wr_addr] takes wr_data; all other registers hold.
REQ-014 Register 31 (XZR) is hardwired: regs_out[31] is always 0, and writes to index 31 are discarded silently.
REQ-015 Write latency is one edge: regs_out reflects the new value in the cycle after the write edge; no same-cycle bypass into regs_out.
REQ-016 With wr_en=0, wr_addr and wr_data are don't-care; no register changes.
REQ-017 last_wr_valid is registered as wr_en AND (wr_addr!=31); last_wr_addr and last_wr_data are registered from wr_addr and wr_data on every edge.
REQ-018 last_wr_* gives the hazard/forwarding unit a one-cycle write-back echo; it has no effect on storage.
REQ-019 Back-to-back writes to the same index: the later write wins; each write is visible one cycle after its edge.
REQ-020 No read ports, arithmetic or flags inside this block; reading stays with the external read mux.

Reset
REQ-021 reset=1 at a rising edge: all 32 registers clear to 0, last_wr_valid=0, last_wr_addr=0, last_wr_data=0.
REQ-022 reset takes priority over a simultaneous wr_en=1; that write is lost.
REQ-023 Reset mid-sequence leaves no partial state; the first write after reset deassertion completes normally.
REQ-024 Contents before the first reset edge are undefined and are not checked.

Structure
REQ-025 Shared package regfile_pkg holds DATA_W=64, NUM_REGS=32, ADDR_W=5, ZERO_REG=5'd31 and the typedef reg_array_t ([31:0][63:0]), also used by the read side.
REQ-026 One sub-module: decoder5_32 (inputs en, addr[4:0]; output onehot[31:0]), instantiated once.
REQ-027 Storage is 31 enabled 64-bit registers built in a generate loop over indices 0..30; index 31 is a constant tie-off.

Verification
REQ-028 Reset, then wr_en=1, addr=5, data=64'hDEAD_BEEF_0000_0005 -> next cycle regs_out[5] holds that value, all other registers 0, last_wr_valid=1, last_wr_addr=5.
REQ-029 wr_en=1, addr=31, data=64'hFFFF_FFFF_FFFF_FFFF -> regs_out[31] stays 0, last_wr_valid=0, no other register changes.
REQ-030 wr_en=0, addr=7, data=64'h1234 -> regs_out[7] unchanged, last_wr_valid=0.
REQ-031 Consecutive writes addr=3 data=1, then addr=3 data=2 -> regs_out[3]=1 after the first edge and 2 after the second.
REQ-032 Fill registers 0..30 with value=index+100, then reset=1 and wr_en=1 (addr=0, data=9) in the same cycle -> all registers 0, last_wr_valid=0.
REQ-033 Random write stream of 1000 cycles checked against a 32-entry scoreboard every cycle, including index 31 and wr_en toggling.
